// File: rtl/vid_pkg.sv
// Shared definitions for the video stream sink blocks: error codes and FSM states.
package vid_pkg;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_NO_SOP      = 3'd1;
    localparam logic [2:0] ERR_EARLY_SOP   = 3'd2;
    localparam logic [2:0] ERR_EARLY_EOP   = 3'd3;
    localparam logic [2:0] ERR_MISSING_EOP = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } vid_state_t;

endpackage

// File: rtl/vid_ready_lfsr.sv
// Pseudo-random registered ready for stream sinks; high on roughly READY_PERC percent of cycles.
module vid_ready_lfsr #(
    parameter int READY_PERC = 100
) (
    input  logic clk,
    input  logic srst,
    output logic ready
);

    localparam int   THRESH    = READY_PERC * 256 / 100;
    localparam logic FORCE_ON  = (READY_PERC >= 100);
    localparam logic FORCE_OFF = (READY_PERC <= 0);

    logic [7:0] lfsr_reg;
    logic       ready_reg;
    logic       lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign ready   = ready_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_reg  <= 8'hA5;
            ready_reg <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
            if (FORCE_ON)
                ready_reg <= 1'b1;
            else if (FORCE_OFF)
                ready_reg <= 1'b0;
            else
                ready_reg <= ({1'b0, lfsr_reg} < 9'(THRESH));
        end
    end

endmodule

// File: rtl/vid_stream_checker.sv
// Latency-0 video stream sink: drives backpressure, checks sop/eop framing against
// ROWS x COLS and reports per-frame status, checksum and error statistics.
module vid_stream_checker
    import vid_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int ROWS       = 240,
    parameter int COLS       = 320,
    parameter int READY_PERC = 100,
    parameter int SUM_W      = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [BITS-1:0]  data,
    input  logic             sop,
    input  logic             eop,
    input  logic             valid,
    output logic             ready,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [SUM_W-1:0] frame_sum,
    output logic [15:0]      frame_count,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [15:0]      err_count
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    // Position after the sop beat; a single-column frame wraps straight to row 1
    localparam logic [COL_W-1:0] COL_START = (COLS > 1) ? COL_W'(1) : '0;
    localparam logic [ROW_W-1:0] ROW_START = (COLS > 1) ? '0 : ROW_W'(1);

    vid_state_t       state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [SUM_W-1:0] sum_reg, sum_next;
    logic             frame_done_reg, frame_done_next;
    logic             frame_ok_reg, frame_ok_next;
    logic [SUM_W-1:0] frame_sum_reg, frame_sum_next;
    logic [15:0]      frame_count_reg, frame_count_next;
    logic             err_reg, err_next;
    logic [2:0]       err_code_reg, err_code_next;
    logic [15:0]      err_count_reg, err_count_next;

    logic             accept;
    logic             last_pos;
    logic [SUM_W-1:0] sum_plus;

    vid_ready_lfsr #(
        .READY_PERC (READY_PERC)
    ) u_ready (
        .clk   (clk),
        .srst  (srst),
        .ready (ready)
    );

    assign accept   = valid & ready;
    assign last_pos = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    assign sum_plus = sum_reg + SUM_W'(data);

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        row_next         = row_reg;
        sum_next         = sum_reg;
        frame_done_next  = 1'b0;
        frame_ok_next    = frame_ok_reg;
        frame_sum_next   = frame_sum_reg;
        frame_count_next = frame_count_reg;
        err_next         = 1'b0;
        err_code_next    = err_code_reg;

        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (sop) begin
                        state_next = ST_ACTIVE;
                        col_next   = COL_START;
                        row_next   = ROW_START;
                        sum_next   = SUM_W'(data);
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = ERR_NO_SOP;
                    end
                end
                default: begin
                    if (sop) begin
                        // Close the broken frame with its old sum, then restart on this beat
                        err_next        = 1'b1;
                        err_code_next   = ERR_EARLY_SOP;
                        frame_done_next = 1'b1;
                        frame_ok_next   = 1'b0;
                        frame_sum_next  = sum_reg;
                        col_next        = COL_START;
                        row_next        = ROW_START;
                        sum_next        = SUM_W'(data);
                    end else if (eop || last_pos) begin
                        state_next      = ST_IDLE;
                        frame_done_next = 1'b1;
                        frame_sum_next  = sum_plus;
                        frame_ok_next   = eop && last_pos;
                        if (eop && last_pos) begin
                            frame_count_next = frame_count_reg + 16'd1;
                        end else begin
                            err_next      = 1'b1;
                            err_code_next = eop ? ERR_EARLY_EOP : ERR_MISSING_EOP;
                        end
                    end else begin
                        sum_next = sum_plus;
                        if (col_reg == COL_LAST) begin
                            col_next = '0;
                            row_next = row_reg + ROW_W'(1);
                        end else begin
                            col_next = col_reg + COL_W'(1);
                        end
                    end
                end
            endcase
        end

        err_count_next = err_count_reg;
        if (err_next && (err_count_reg != 16'hFFFF))
            err_count_next = err_count_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg       <= ST_IDLE;
            col_reg         <= '0;
            row_reg         <= '0;
            sum_reg         <= '0;
            frame_done_reg  <= 1'b0;
            frame_ok_reg    <= 1'b0;
            frame_sum_reg   <= '0;
            frame_count_reg <= '0;
            err_reg         <= 1'b0;
            err_code_reg    <= ERR_NONE;
            err_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            row_reg         <= row_next;
            sum_reg         <= sum_next;
            frame_done_reg  <= frame_done_next;
            frame_ok_reg    <= frame_ok_next;
            frame_sum_reg   <= frame_sum_next;
            frame_count_reg <= frame_count_next;
            err_reg         <= err_next;
            err_code_reg    <= err_code_next;
            err_count_reg   <= err_count_next;
        end
    end

    assign frame_done  = frame_done_reg;
    assign frame_ok    = frame_ok_reg;
    assign frame_sum   = frame_sum_reg;
    assign frame_count = frame_count_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_vid_stream_checker.sv
// Directed bench for vid_stream_checker on a 4x4 frame: table vectors plus reset and backpressure runs.
module tb_vid_stream_checker;

    logic        clk = 1'b0;
    logic        srst = 1'b1;

    logic [7:0]  data = '0;
    logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
    logic        ready, frame_done, frame_ok, err;
    logic [15:0] frame_sum, frame_count, err_count;
    logic [2:0]  err_code;

    logic [7:0]  data2 = '0;
    logic        sop2 = 1'b0, eop2 = 1'b0, valid2 = 1'b0;
    logic        ready2, frame_done2, frame_ok2, err2;
    logic [15:0] frame_sum2, frame_count2, err_count2;
    logic [2:0]  err_code2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vid_stream_checker #(.BITS(8), .ROWS(4), .COLS(4), .READY_PERC(100), .SUM_W(16)) dut (
        .clk(clk), .srst(srst), .data(data), .sop(sop), .eop(eop), .valid(valid),
        .ready(ready), .frame_done(frame_done), .frame_ok(frame_ok), .frame_sum(frame_sum),
        .frame_count(frame_count), .err(err), .err_code(err_code), .err_count(err_count)
    );

    vid_stream_checker #(.BITS(8), .ROWS(4), .COLS(4), .READY_PERC(10), .SUM_W(16)) dut10 (
        .clk(clk), .srst(srst), .data(data2), .sop(sop2), .eop(eop2), .valid(valid2),
        .ready(ready2), .frame_done(frame_done2), .frame_ok(frame_ok2), .frame_sum(frame_sum2),
        .frame_count(frame_count2), .err(err2), .err_code(err_code2), .err_count(err_count2)
    );

    typedef struct {
        logic [7:0]  d;
        logic        s;
        logic        e;
        logic        done;
        logic        ok;
        logic [15:0] sum;
        logic [15:0] cnt;
        logic        er;
        logic [2:0]  code;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] d, input logic s, input logic e,
                                input logic dn, input logic ok, input logic [15:0] sm,
                                input logic [15:0] cn, input logic er, input logic [2:0] cd,
                                input logic [15:0] ec);
        vec_t v;
        v.d = d; v.s = s; v.e = e; v.done = dn; v.ok = ok; v.sum = sm;
        v.cnt = cn; v.er = er; v.code = cd; v.ecnt = ec;
        vecs.push_back(v);
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int waited;
        data = d; sop = s; eop = e; valid = 1'b1;
        waited = 0;
        while (!ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            $display("FAIL send_timeout: got=ready_low want=ready_high");
            bad++;
            total++;
        end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic dn, input logic ok,
                                 input logic [15:0] sm, input logic [15:0] cn, input logic er,
                                 input logic [2:0] cd, input logic [15:0] ec);
        check({tag, "_done"},  frame_done,  dn);
        check({tag, "_ok"},    frame_ok,    ok);
        check({tag, "_sum"},   frame_sum,   sm);
        check({tag, "_count"}, frame_count, cn);
        check({tag, "_err"},   err,         er);
        check({tag, "_code"},  err_code,    cd);
        check({tag, "_ecnt"},  err_count,   ec);
    endtask

    initial begin
        logic [15:0] msum;
        int          pos;
        int          rdy_cnt;
        int          frames;
        logic [15:0] exp_q[$];

        // T1: clean frame 0..15
        for (int i = 0; i < 16; i++)
            if (i < 15) add(8'(i), i == 0, 1'b0, 0, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
            else        add(8'(i), 1'b0, 1'b1, 1, 1, 16'd120, 16'd1, 0, 3'd0, 16'd0);
        // T2: eop on beat 9
        for (int i = 0; i < 10; i++)
            if (i < 9) add(8'(i), i == 0, 1'b0, 0, 1, 16'd120, 16'd1, 0, 3'd0, 16'd0);
            else       add(8'(i), 1'b0, 1'b1, 1, 0, 16'd45, 16'd1, 1, 3'd3, 16'd1);
        // T3: sop again on beat 6, then a clean frame of ones
        for (int i = 0; i < 6; i++)
            add(8'(i), i == 0, 1'b0, 0, 0, 16'd45, 16'd1, 0, 3'd3, 16'd1);
        for (int j = 0; j < 16; j++)
            if (j == 0)       add(8'd1, 1'b1, 1'b0, 1, 0, 16'd15, 16'd1, 1, 3'd2, 16'd2);
            else if (j < 15)  add(8'd1, 1'b0, 1'b0, 0, 0, 16'd15, 16'd1, 0, 3'd2, 16'd2);
            else              add(8'd1, 1'b0, 1'b1, 1, 1, 16'd16, 16'd2, 0, 3'd2, 16'd2);
        // T4: no eop on last pixel, then a stray beat without sop
        for (int j = 0; j < 16; j++)
            if (j < 15) add(8'd2, j == 0, 1'b0, 0, 1, 16'd16, 16'd2, 0, 3'd2, 16'd2);
            else        add(8'd2, 1'b0, 1'b0, 1, 0, 16'd32, 16'd2, 1, 3'd4, 16'd3);
        add(8'd7, 1'b0, 1'b0, 0, 0, 16'd32, 16'd2, 1, 3'd1, 16'd4);

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check_outputs("rst", 0, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
        srst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].d, vecs[i].s, vecs[i].e);
            $display("vec %0d d=%0d sop=%0b eop=%0b -> done=%0b ok=%0b sum=%0d cnt=%0d err=%0b code=%0d ecnt=%0d",
                     i, vecs[i].d, vecs[i].s, vecs[i].e, frame_done, frame_ok, frame_sum,
                     frame_count, err, err_code, err_count);
            check_outputs($sformatf("v%0d", i), vecs[i].done, vecs[i].ok, vecs[i].sum,
                          vecs[i].cnt, vecs[i].er, vecs[i].code, vecs[i].ecnt);
        end

        // T6: reset in the middle of a frame
        for (int i = 0; i < 7; i++) send(8'd9, i == 0, 1'b0);
        srst = 1'b1; valid = 1'b1; data = 8'd5; eop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("t6_rst_ready%0d", i), ready, 1'b0);
            check($sformatf("t6_rst_done%0d", i), frame_done, 1'b0);
            check($sformatf("t6_rst_err%0d", i), err, 1'b0);
        end
        srst = 1'b0; valid = 1'b0; eop = 1'b0;
        check_outputs("t6_after_rst", 0, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
        for (int j = 0; j < 16; j++) begin
            send(8'd3, j == 0, j == 15);
            if (j < 15) check($sformatf("t6_nodone%0d", j), frame_done, 1'b0);
        end
        $display("t6 frame: done=%0b ok=%0b sum=%0d cnt=%0d ecnt=%0d",
                 frame_done, frame_ok, frame_sum, frame_count, err_count);
        check_outputs("t6_frame", 1, 1, 16'd48, 16'd1, 0, 3'd0, 16'd0);

        // T5: 10% ready, valid held high, garbage on cycles that are not accepted
        pos = 0; msum = '0; rdy_cnt = 0; frames = 0;
        valid2 = 1'b1;
        for (int cyc = 0; cyc <= 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check("t5_err", err2, 1'b0);
            if (frame_done2) begin
                if (exp_q.size() == 0) begin
                    check("t5_unexpected_done", frame_done2, 1'b0);
                end else begin
                    $display("t5 frame %0d: ok=%0b sum=%0h want=%0h", frames, frame_ok2, frame_sum2, exp_q[0]);
                    check("t5_ok", frame_ok2, 1'b1);
                    check("t5_sum", frame_sum2, exp_q.pop_front());
                    frames++;
                end
            end
            if (cyc == 2000) break;
            data2 = 8'($urandom);
            if (ready2) begin
                rdy_cnt++;
                sop2 = (pos == 0);
                eop2 = (pos == 15);
                msum = (pos == 0) ? {8'd0, data2} : msum + {8'd0, data2};
                if (pos == 15) begin
                    exp_q.push_back(msum);
                    pos = 0;
                end else begin
                    pos++;
                end
            end else begin
                sop2 = 1'($urandom);
                eop2 = 1'($urandom);
            end
        end
        valid2 = 1'b0;
        $display("t5 summary: ready_cycles=%0d of 2000 frames=%0d", rdy_cnt, frames);
        check("t5_duty_range", (rdy_cnt >= 100 && rdy_cnt <= 300), 1'b1);
        check("t5_pending", exp_q.size(), 0);
        check("t5_frame_count", frame_count2, 16'(frames));
        check("t5_err_count", err_count2, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vid_stream_checker.md
Name: vid_stream_checker

Overview:
- Latency-0 video stream sink that terminates the {data, sop, eop, valid, ready} pixel stream produced by video_gen.
- Drives a pseudo-random ready to exercise upstream backpressure.
- Tracks row/column position, validates sop/eop framing against ROWS x COLS and reports per-frame status, checksum and error counts.
- Used in benches as a synthesizable self-checking sink after stream_latency_1_to_0 or directly after video_gen.

Parameters:
BITS, 8, pixel data width
ROWS, 240, lines per frame (ROWS*COLS >= 2)
COLS, 320, pixels per line
READY_PERC, 100, percent of cycles ready is high (0..100; >=100 means ready constant 1 outside reset)
SUM_W, 16, checksum width

Ports:
clk  input  1  clock
srst  input  1  synchronous active-high reset
data  input  BITS  pixel data
sop  input  1  start of frame, marks first pixel
eop  input  1  end of frame, marks last pixel
valid  input  1  beat valid
ready  output  1  sink ready; beat accepted when valid & ready in same cycle (latency 0)
frame_done  output  1  one-cycle pulse, frame terminated
frame_ok  output  1  status of last terminated frame, held
frame_sum  output  SUM_W  sum of accepted pixels of last terminated frame mod 2^SUM_W, held
frame_count  output  16  count of frame_ok frames, wraps
err  output  1  one-cycle pulse, framing error
err_code  output  3  last error code, held
err_count  output  16  error count, saturates at 16'hFFFF

Behaviour:
- Interface fixed: one clock clk; reset srst is synchronous and active-high.
- Reset: ready=0, frame_done=0, frame_ok=0, frame_sum=0, frame_count=0, err=0, err_code=0, err_count=0, FSM=IDLE, col=row=0, running sum=0, LFSR=8'hA5. srst mid-frame discards the partial frame with no frame_done and no err.
- Ready generator: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every cycle outside reset. THRESH = READY_PERC*256/100, a localparam. ready <= (lfsr < THRESH), registered. READY_PERC>=100 forces ready=1. READY_PERC=0 forces ready=0.
- Only accepted beats (valid & ready) affect state. Non-accepted cycles hold state.
- FSM IDLE, accepted beat:
  - sop=1: enter ACTIVE; col=1, row=0; sum=data.
  - sop=0: err pulse, code 1 NO_SOP; beat dropped; stay IDLE.
- FSM ACTIVE, accepted beat, checked in priority order:
  - sop=1: err, code 2 EARLY_SOP; frame_done with frame_ok=0 and the old sum; restart the frame with this beat as in IDLE.
  - eop=1 at the last position (col==COLS-1 and row==ROWS-1): frame_done, frame_ok=1, frame_sum=sum+data, frame_count+1; go to IDLE.
  - eop=1 at any other position: err, code 3 EARLY_EOP; frame_done, frame_ok=0, frame_sum=sum+data; go to IDLE.
  - last position with eop=0: err, code 4 MISSING_EOP; frame_done, frame_ok=0, frame_sum=sum+data; go to IDLE.
  - otherwise: sum+=data; col+1; when col reaches COLS-1 the next beat wraps col to 0 and increments row.
- Latency: all status outputs register one cycle after the accepted beat.
- At most one err per beat. err_count increments on each err pulse and saturates.
- Sum arithmetic: zero-extend data to SUM_W; additions wrap mod 2^SUM_W.
- Counter widths: col is $clog2(COLS), row is $clog2(ROWS).

Decomposition:
- Shared package/include vid_pkg: error codes ERR_NONE=0, ERR_NO_SOP=1, ERR_EARLY_SOP=2, ERR_EARLY_EOP=3, ERR_MISSING_EOP=4; FSM state encodings.
- One sub-module, vid_ready_lfsr (clk, srst, READY_PERC, output ready), reusable by other sinks.

Test Plan (ROWS=4, COLS=4, BITS=8 unless stated):
1. READY_PERC=100, one frame of data 0..15, sop on beat 0, eop on beat 15 -> single frame_done with frame_ok=1, frame_sum=120, frame_count=1, err_count=0.
2. Frame with eop on beat 9 (data 0..9) -> err with err_code=3, frame_done with frame_ok=0, frame_sum=45, frame_count=0, err_count=1.
3. sop again on beat 6, then a clean 16-beat frame of data 1 -> err code 2 and frame_ok=0 for the first frame; second frame_done frame_ok=1, frame_sum=16, frame_count=1.
4. 16 beats with no eop, then one beat with sop=0 -> code 4 on beat 16 with frame_done frame_ok=0; next cycle code 1; err_count=2.
5. READY_PERC=10, valid held high for 2000 cycles of clean frames -> ready duty between 5% and 15%; no state change on ready=0 cycles; every frame_ok=1 and frame_sum matches the bench model.
6. srst asserted for 2 cycles after 7 accepted beats -> all outputs reset, ready=0 during srst, no frame_done; a following clean frame gives frame_count=1, err_count=0.
